// File: rtl/pwl_interp_pipe.sv
// Three-stage piecewise-linear interpolator with a runtime-loadable breakpoint table.
// The whole pipeline advances together whenever the output slot is free or is being drained.
module pwl_interp_pipe #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4,
  parameter int ADDR_W = DATA_W - FRAC_W,
  parameter int ROUND  = 0,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              tbl_we,
  input  logic [ADDR_W:0]   tbl_addr,
  input  logic [DATA_W-1:0] tbl_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_y,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int NENT = (1 << ADDR_W) + 1;
  localparam int PW   = DATA_W + FRAC_W + 2;
  localparam logic [ADDR_W-1:0] IDX_FLIP = ADDR_W'(1) << (ADDR_W - 1);
  localparam logic [ADDR_W:0]   ADDR_MAX = (ADDR_W + 1)'(NENT - 1);
  localparam logic signed [PW-1:0] RND = (ROUND != 0) ? (PW'(1) << (FRAC_W - 1)) : '0;

  logic [DATA_W-1:0] tbl_q [NENT];

  logic [3:1] vld_q;
  logic       en;

  logic [DATA_W-1:0] base1_q, next1_q;
  logic [FRAC_W-1:0] rem1_q;
  logic [TAG_W-1:0]  tag1_q;

  logic signed [PW-1:0] prod2_q;
  logic [DATA_W-1:0]    base2_q;
  logic [TAG_W-1:0]     tag2_q;

  logic [DATA_W-1:0] y3_q;
  logic [TAG_W-1:0]  tag3_q;

  logic [ADDR_W-1:0]      idx;
  logic [ADDR_W:0]        idx_lo, idx_hi;
  logic signed [DATA_W:0] diff;
  logic signed [PW-1:0]   prod_d, sh;
  logic [DATA_W-1:0]      y_d;

  assign en       = !vld_q[3] || out_ready;
  assign in_ready = en;

  // Offset-binary segment index: most-negative x lands on entry 0.
  assign idx    = in_x[DATA_W-1:FRAC_W] ^ IDX_FLIP;
  assign idx_lo = {1'b0, idx};
  assign idx_hi = idx_lo + 1'b1;

  assign diff   = $signed({next1_q[DATA_W-1], next1_q}) - $signed({base1_q[DATA_W-1], base1_q});
  assign prod_d = PW'(diff) * $signed({{(PW-FRAC_W){1'b0}}, rem1_q});
  assign sh     = (prod2_q + RND) >>> FRAC_W;
  assign y_d    = DATA_W'(PW'($signed(base2_q)) + sh);

  // Table write lands at the clock edge, so a sample accepted on the same edge sees the old entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NENT; i++) tbl_q[i] <= '0;
    end else if (tbl_we && (tbl_addr <= ADDR_MAX)) begin
      tbl_q[tbl_addr] <= tbl_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q   <= '0;
      base1_q <= '0;
      next1_q <= '0;
      rem1_q  <= '0;
      tag1_q  <= '0;
      prod2_q <= '0;
      base2_q <= '0;
      tag2_q  <= '0;
      y3_q    <= '0;
      tag3_q  <= '0;
    end else if (en) begin
      vld_q   <= {vld_q[2:1], in_valid};
      base1_q <= tbl_q[idx_lo];
      next1_q <= tbl_q[idx_hi];
      rem1_q  <= in_x[FRAC_W-1:0];
      tag1_q  <= in_tag;
      prod2_q <= prod_d;
      base2_q <= base1_q;
      tag2_q  <= tag1_q;
      y3_q    <= y_d;
      tag3_q  <= tag2_q;
    end
  end

  assign out_valid = vld_q[3];
  assign out_y     = y3_q;
  assign out_tag   = tag3_q;

endmodule

// File: tb/tb_pwl_interp_pipe.sv
// Directed bench: floor and round-half-up instances driven in parallel, hand-computed results.
module tb_pwl_interp_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_x;
  logic [3:0] in_tag;
  logic       tbl_we;
  logic [4:0] tbl_addr;
  logic [7:0] tbl_wdata;
  logic       out_ready;

  logic       in_ready, out_valid;
  logic [7:0] out_y;
  logic [3:0] out_tag;
  logic       in_ready1, out_valid1;
  logic [7:0] out_y1;
  logic [3:0] out_tag1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwl_interp_pipe #(.DATA_W(8), .FRAC_W(4), .ROUND(0), .TAG_W(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .in_tag(in_tag), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_tag(out_tag));

  pwl_interp_pipe #(.DATA_W(8), .FRAC_W(4), .ROUND(1), .TAG_W(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_x(in_x),
    .in_tag(in_tag), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .out_valid(out_valid1), .out_ready(out_ready), .out_y(out_y1), .out_tag(out_tag1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    tbl_we = 1'b1; tbl_addr = a; tbl_wdata = d;
    tick();
    tbl_we = 1'b0;
  endtask

  // One isolated sample; returns out_valid one edge early and the result at the third edge.
  task automatic run_one(input logic [7:0] x, input logic [3:0] tag, output logic v_early,
                         output logic v, output logic [7:0] y0, output logic [7:0] y1,
                         output logic [3:0] t);
    out_ready = 1'b1;
    in_valid = 1'b1; in_x = x; in_tag = tag;
    tick();
    in_valid = 1'b0;
    tick();
    v_early = out_valid;
    tick();
    v = out_valid && out_valid1; y0 = out_y; y1 = out_y1; t = out_tag;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_x = '0; in_tag = '0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0; out_ready = 1'b1;
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_y !== 8'h00) begin n_err++; $display("FAIL reset_out_y got %0d want 0", out_y); end
    n_cmp++; if (out_tag !== 4'h0) begin n_err++; $display("FAIL reset_out_tag got %0d want 0", out_tag); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_defaults();
    logic ve, v; logic [7:0] y0, y1; logic [3:0] t;
    wr(5'd8, 8'd16); wr(5'd9, 8'd48);
    run_one(8'h08, 4'd3, ve, v, y0, y1, t);
    n_cmp++; if (ve !== 1'b0) begin n_err++; $display("FAIL latency_early got %b want 0", ve); end
    n_cmp++; if (v !== 1'b1) begin n_err++; $display("FAIL latency_valid got %b want 1", v); end
    n_cmp++; if (y0 !== 8'd32) begin n_err++; $display("FAIL mid_seg got %0d want 32", $signed(y0)); end
    n_cmp++; if (y1 !== 8'd32) begin n_err++; $display("FAIL mid_seg_rnd got %0d want 32", $signed(y1)); end
    n_cmp++; if (t !== 4'd3) begin n_err++; $display("FAIL mid_seg_tag got %0d want 3", t); end
    run_one(8'h00, 4'd4, ve, v, y0, y1, t);
    n_cmp++; if (y0 !== 8'd16) begin n_err++; $display("FAIL x_zero got %0d want 16", $signed(y0)); end
    n_cmp++; if (t !== 4'd4) begin n_err++; $display("FAIL x_zero_tag got %0d want 4", t); end
  endtask

  task automatic test_neg_slope();
    logic ve, v; logic [7:0] y0, y1; logic [3:0] t;
    wr(5'd8, 8'd48); wr(5'd9, 8'd16);
    run_one(8'h05, 4'd1, ve, v, y0, y1, t);
    n_cmp++; if (y0 !== 8'd38) begin n_err++; $display("FAIL neg_slope got %0d want 38", $signed(y0)); end
    n_cmp++; if (y1 !== 8'd38) begin n_err++; $display("FAIL neg_slope_rnd got %0d want 38", $signed(y1)); end
  endtask

  task automatic test_rounding();
    logic ve, v; logic [7:0] y0, y1; logic [3:0] t;
    wr(5'd8, 8'd10); wr(5'd9, 8'd13);
    run_one(8'h05, 4'd2, ve, v, y0, y1, t);
    n_cmp++; if (y0 !== 8'd10) begin n_err++; $display("FAIL round_floor got %0d want 10", $signed(y0)); end
    n_cmp++; if (y1 !== 8'd11) begin n_err++; $display("FAIL round_half_up got %0d want 11", $signed(y1)); end
  endtask

  task automatic test_range_ends();
    logic ve, v; logic [7:0] y0, y1; logic [3:0] t;
    wr(5'd0, 8'hF9); wr(5'd1, 8'd0);
    run_one(8'h80, 4'd5, ve, v, y0, y1, t);
    n_cmp++; if (y0 !== 8'hF9) begin n_err++; $display("FAIL x_min got %0d want -7", $signed(y0)); end
    wr(5'd15, 8'd0); wr(5'd16, 8'd16);
    run_one(8'h7F, 4'd6, ve, v, y0, y1, t);
    n_cmp++; if (y0 !== 8'd15) begin n_err++; $display("FAIL x_max got %0d want 15", $signed(y0)); end
    n_cmp++; if (y1 !== 8'd15) begin n_err++; $display("FAIL x_max_rnd got %0d want 15", $signed(y1)); end
  endtask

  task automatic test_backpressure();
    int exp_y [8] = '{16, 20, 24, 28, 32, 36, 40, 44};
    int sent = 0;
    int got = 0;
    logic [7:0] hy = '0;
    logic [3:0] ht = '0;
    bit hold = 0;
    wr(5'd8, 8'd16); wr(5'd9, 8'd48);
    for (int c = 0; c < 60 && got < 8; c++) begin
      out_ready = !(c >= 5 && c < 10);
      in_valid = (sent < 8);
      in_x = 8'(2 * sent);
      in_tag = 4'(sent);
      #1;
      if (!out_ready) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready c=%0d got %b want 0", c, in_ready); end
        if (hold) begin
          n_cmp++;
          if (out_valid !== 1'b1 || out_y !== hy || out_tag !== ht) begin
            n_err++;
            $display("FAIL bp_stable c=%0d got v=%b y=%0d t=%0d want v=1 y=%0d t=%0d",
                     c, out_valid, out_y, out_tag, hy, ht);
          end
        end
        hy = out_y; ht = out_tag; hold = 1;
      end else begin
        hold = 0;
      end
      if (out_valid && out_ready) begin
        n_cmp++; if (out_tag !== 4'(got)) begin n_err++; $display("FAIL bp_tag got %0d want %0d", out_tag, got); end
        n_cmp++; if (out_y !== 8'(exp_y[got])) begin n_err++; $display("FAIL bp_y tag=%0d got %0d want %0d", got, out_y, exp_y[got]); end
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (got !== 8) begin n_err++; $display("FAIL bp_count got %0d want 8", got); end
    tick(); tick(); tick();
  endtask

  task automatic test_write_hazard();
    logic ve, v; logic [7:0] y0, y1; logic [3:0] t;
    out_ready = 1'b1;
    tbl_we = 1'b1; tbl_addr = 5'd8; tbl_wdata = 8'd100;
    in_valid = 1'b1; in_x = 8'h00; in_tag = 4'd9;
    tick();
    tbl_we = 1'b0; in_valid = 1'b0;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b1 || out_y !== 8'd16) begin n_err++; $display("FAIL hazard_old got v=%b y=%0d want v=1 y=16", out_valid, out_y); end
    n_cmp++; if (out_tag !== 4'd9) begin n_err++; $display("FAIL hazard_tag got %0d want 9", out_tag); end
    tick();
    run_one(8'h00, 4'd10, ve, v, y0, y1, t);
    n_cmp++; if (y0 !== 8'd100) begin n_err++; $display("FAIL hazard_new got %0d want 100", y0); end
    wr(5'd1, 8'd5);
    wr(5'd17, 8'd55);
    run_one(8'h90, 4'd11, ve, v, y0, y1, t);
    n_cmp++; if (y0 !== 8'd5) begin n_err++; $display("FAIL oob_write_e1 got %0d want 5", y0); end
    run_one(8'h7F, 4'd12, ve, v, y0, y1, t);
    n_cmp++; if (y0 !== 8'd15) begin n_err++; $display("FAIL oob_write_e16 got %0d want 15", y0); end
  endtask

  task automatic test_reset_midstream();
    logic ve, v; logic [7:0] y0, y1; logic [3:0] t;
    int seen = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_x = 8'h00; in_tag = 4'd7;
    tick(); tick(); tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_full got %b want 1", out_valid); end
    rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_valid1 !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
    n_cmp++; if (out_y !== 8'h00) begin n_err++; $display("FAIL mid_rst_y got %0d want 0", out_y); end
    n_cmp++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready got %b want 1", in_ready1); end
    tick();
    rst = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL mid_stale got %0d want 0", seen); end
    run_one(8'h08, 4'd1, ve, v, y0, y1, t);
    n_cmp++; if (y0 !== 8'd0) begin n_err++; $display("FAIL cleared_mid got %0d want 0", y0); end
    run_one(8'h7F, 4'd2, ve, v, y0, y1, t);
    n_cmp++; if (y0 !== 8'd0) begin n_err++; $display("FAIL cleared_max got %0d want 0", y0); end
    run_one(8'h00, 4'd3, ve, v, y0, y1, t);
    n_cmp++; if (y0 !== 8'd0) begin n_err++; $display("FAIL cleared_zero got %0d want 0", y0); end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_neg_slope();
    test_rounding();
    test_range_ends();
    test_backpressure();
    test_write_hazard();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwl_interp_pipe.md
# pwl_interp_pipe

Pipelined, parametrised piecewise-linear interpolator for activation-function lookup in the neuron layer datapath. It holds a runtime-loadable breakpoint table, splits each signed input into a segment index and a fractional remainder, and interpolates between adjacent breakpoints. A 3-stage pipeline with valid/ready handshake carries a sideband tag through to the output. It replaces the fixed 8-bit, 4-fraction-bit combinational interpolator used per activation function.

## Interface
- DATA_W, 8: signed width of input x, table entries and result.
- FRAC_W, 4: remainder bits (low bits of x); interpolation shift amount. 1 ≤ FRAC_W < DATA_W.
- ADDR_W, DATA_W-FRAC_W: segment index bits; table has 2^ADDR_W+1 entries.
- ROUND, 0: 0 = floor (arithmetic shift), 1 = round-half-up (add 2^(FRAC_W-1) before shift).
- TAG_W, 4: sideband tag width.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts input this cycle.
- in_x  in  DATA_W  signed input sample.
- in_tag  in  TAG_W  sideband tag, returned unchanged with the result.
- tbl_we  in  1  table write enable.
- tbl_addr  in  ADDR_W+1  table entry address, 0..2^ADDR_W.
- tbl_wdata  in  DATA_W  signed table entry.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_y  out  DATA_W  signed interpolated result.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Index: idx = in_x[DATA_W-1:FRAC_W] with MSB inverted (offset binary), so most-negative x maps to 0 and x=0 maps to 2^(ADDR_W-1). rem = in_x[FRAC_W-1:0], unsigned.
- base = tbl[idx], next = tbl[idx+1]; idx+1 ≤ 2^ADDR_W always, no wrap.
- diff = next − base, DATA_W+1 signed. prod = diff × rem (rem zero-extended), signed, DATA_W+FRAC_W+2 bits.
- sh = (prod + (ROUND ? 2^(FRAC_W-1) : 0)) >>> FRAC_W (arithmetic).
- out_y = base + sh, truncated to DATA_W. Result always lies between base and next inclusive, so truncation never loses magnitude.
- Table write:
  - Writes with tbl_addr > 2^ADDR_W are ignored.
  - A write in cycle N is visible to samples accepted in cycle N+1 or later.
  - A sample accepted in cycle N reads the pre-write value.
  - Writes are accepted regardless of handshake state.
- Stages:
  - S1 registers base, next, rem, tag.
  - S2 registers prod, base, tag.
  - S3 registers out_y, out_tag.
  - Each stage has a valid bit.

## Timing
- Reset (rst=0, asynchronous): all table entries = 0, all stage valid bits = 0, out_valid = 0, out_y = 0, out_tag = 0. in_ready is combinational and reads 1 during reset release.
- Global advance en = !out_valid || out_ready. in_ready = en. All stages shift when en=1; none shift when en=0.
- Accept when in_valid && in_ready. Latency: a sample accepted in cycle N gives out_valid in cycle N+3 if en stays 1.
- Bubbles are not compressed; they shift through with the pipeline.
- Throughput: 1 sample/cycle with out_ready held high.
- out_y, out_tag and out_valid are stable while out_valid=1 && out_ready=0.
- When out_ready rises after a stall, the held result is consumed and a new sample may be accepted in the same cycle.
- Reset asserted mid-operation: in-flight samples are discarded and the table is cleared. After release, the table must be reloaded before results are meaningful.
- Order is preserved; tags exit in acceptance order.

## Test plan
- Defaults. tbl[8]=16, tbl[9]=48, in_x=0x08 -> out_y=32 three cycles after acceptance. in_x=0x00 -> out_y=16.
- Negative slope. tbl[8]=48, tbl[9]=16, in_x=0x05 -> diff=−32, prod=−160, out_y=38.
- Rounding. tbl[8]=10, tbl[9]=13, in_x=0x05 -> out_y=10 with ROUND=0 and 11 with ROUND=1. Range ends:
  - in_x=0x80 -> tbl[0].
  - in_x=0x7F with tbl[15]=0, tbl[16]=16 -> out_y=15.
- Backpressure. Stream 8 samples with tags 0..7 and hold out_ready=0 for 5 cycles mid-stream:
  - in_ready drops in the same cycle.
  - out_y and out_tag stay stable.
  - All 8 results emerge in order, with no loss or duplication.
- Write hazard. Write tbl[8]=100 in the same cycle a sample with in_x=0x00 is accepted -> old value is returned. The next sample with in_x=0x00 -> 100. A write to tbl_addr=17 is ignored.
- Reset mid-stream. Assert rst with 3 samples in flight:
  - out_valid=0 immediately; no stale results appear after release.
  - All table entries read back 0: any in_x -> out_y=0.
